// File: rtl/pipe_stall_ctrl.sv
// Hazard-interface producer for the 5-stage pipeline: tracks EXE/MEM destination slots,
// sequences multi-cycle memory accesses and generates freeze/flush/bubble controls.
module pipe_stall_ctrl #(
    parameter int REG_W   = 4,
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_acc,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    output logic [REG_W-1:0] exe_dest,
    output logic             exe_wb_en,
    output logic [REG_W-1:0] mem_dest,
    output logic             mem_wb_en,
    output logic             freeze_if,
    output logic             flush_id,
    output logic             bubble_exe,
    output logic             freeze_pipe,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WCNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;
    localparam bit MULTI_CYCLE = (MEM_LAT > 1);
    localparam logic [WCNT_W-1:0] WAIT_INIT = (MEM_LAT > 1) ? WCNT_W'(MEM_LAT - 2) : '0;

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;

    logic [REG_W-1:0]   exe_dest_q, exe_dest_d;
    logic               exe_wb_en_q, exe_wb_en_d;
    logic               exe_mem_q, exe_mem_d;
    logic [REG_W-1:0]   mem_dest_q, mem_dest_d;
    logic               mem_wb_en_q, mem_wb_en_d;
    logic               mem_mem_q, mem_mem_d;

    logic [CNT_W-1:0]   stall_q, stall_d;

    logic               freeze_pipe_c;
    logic               freeze_if_c;
    logic               flush_id_c;
    logic               bubble_exe_c;

    // Memory wait sequencing: the first MEM cycle freezes from RUN, the rest are counted in WAIT.
    always_comb begin
        freeze_pipe_c = 1'b0;
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        if (MULTI_CYCLE) begin
            case (state_q)
                S_RUN: begin
                    if (mem_mem_q) begin
                        freeze_pipe_c = 1'b1;
                        state_d       = S_WAIT;
                        wait_cnt_d    = WAIT_INIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt_q != '0) begin
                        freeze_pipe_c = 1'b1;
                        wait_cnt_d    = wait_cnt_q - WCNT_W'(1);
                    end else begin
                        state_d = S_RUN;
                    end
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    // Priority: memory freeze > taken branch > data hazard; gated so reset forces all controls low.
    always_comb begin
        freeze_if_c  = 1'b0;
        flush_id_c   = 1'b0;
        bubble_exe_c = 1'b0;
        if (rst_n) begin
            if (freeze_pipe_c) begin
                freeze_if_c = 1'b1;
            end else if (branch_taken) begin
                flush_id_c   = 1'b1;
                bubble_exe_c = 1'b1;
            end else if (hazard_detected) begin
                freeze_if_c  = 1'b1;
                bubble_exe_c = 1'b1;
            end
        end
    end

    always_comb begin
        exe_dest_d  = exe_dest_q;
        exe_wb_en_d = exe_wb_en_q;
        exe_mem_d   = exe_mem_q;
        mem_dest_d  = mem_dest_q;
        mem_wb_en_d = mem_wb_en_q;
        mem_mem_d   = mem_mem_q;
        if (!freeze_pipe_c) begin
            mem_dest_d  = exe_dest_q;
            mem_wb_en_d = exe_wb_en_q;
            mem_mem_d   = exe_mem_q;
            if (bubble_exe_c) begin
                exe_dest_d  = '0;
                exe_wb_en_d = 1'b0;
                exe_mem_d   = 1'b0;
            end else begin
                // An empty ID slot still carries its dest field, but never writes or accesses memory.
                exe_dest_d  = id_dest;
                exe_wb_en_d = id_wb_en & id_valid;
                exe_mem_d   = id_mem_acc & id_valid;
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (freeze_if_c && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            wait_cnt_q  <= '0;
            exe_dest_q  <= '0;
            exe_wb_en_q <= 1'b0;
            exe_mem_q   <= 1'b0;
            mem_dest_q  <= '0;
            mem_wb_en_q <= 1'b0;
            mem_mem_q   <= 1'b0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            exe_dest_q  <= exe_dest_d;
            exe_wb_en_q <= exe_wb_en_d;
            exe_mem_q   <= exe_mem_d;
            mem_dest_q  <= mem_dest_d;
            mem_wb_en_q <= mem_wb_en_d;
            mem_mem_q   <= mem_mem_d;
            stall_q     <= stall_d;
        end
    end

    assign exe_dest     = exe_dest_q;
    assign exe_wb_en    = exe_wb_en_q;
    assign mem_dest     = mem_dest_q;
    assign mem_wb_en    = mem_wb_en_q;
    assign freeze_if    = freeze_if_c;
    assign flush_id     = flush_id_c;
    assign bubble_exe   = bubble_exe_c;
    assign freeze_pipe  = freeze_pipe_c;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with a 3-cycle memory and a 4-bit stall counter.
module tb_pipe_stall_ctrl;

    localparam int REG_W   = 4;
    localparam int MEM_LAT = 3;
    localparam int CNT_W   = 4;

    logic             clk;
    logic             rst_n;
    logic             id_valid;
    logic [REG_W-1:0] id_dest;
    logic             id_wb_en;
    logic             id_mem_acc;
    logic             hazard_detected;
    logic             branch_taken;
    logic [REG_W-1:0] exe_dest;
    logic             exe_wb_en;
    logic [REG_W-1:0] mem_dest;
    logic             mem_wb_en;
    logic             freeze_if;
    logic             flush_id;
    logic             bubble_exe;
    logic             freeze_pipe;
    logic [CNT_W-1:0] stall_cycles;

    logic [3:0]  ctrl;
    logic [17:0] all_out;
    assign ctrl    = {freeze_if, flush_id, bubble_exe, freeze_pipe};
    assign all_out = {exe_dest, exe_wb_en, mem_dest, mem_wb_en, ctrl, stall_cycles};

    int vectors;
    int miscompares;

    pipe_stall_ctrl #(
        .REG_W  (REG_W),
        .MEM_LAT(MEM_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_dest        (id_dest),
        .id_wb_en       (id_wb_en),
        .id_mem_acc     (id_mem_acc),
        .hazard_detected(hazard_detected),
        .branch_taken   (branch_taken),
        .exe_dest       (exe_dest),
        .exe_wb_en      (exe_wb_en),
        .mem_dest       (mem_dest),
        .mem_wb_en      (mem_wb_en),
        .freeze_if      (freeze_if),
        .flush_id       (flush_id),
        .bubble_exe     (bubble_exe),
        .freeze_pipe    (freeze_pipe),
        .stall_cycles   (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_id(input logic v, input logic [REG_W-1:0] d, input logic wb, input logic ma);
        id_valid   = v;
        id_dest    = d;
        id_wb_en   = wb;
        id_mem_acc = ma;
    endtask

    task automatic idle();
        set_id(1'b0, '0, 1'b0, 1'b0);
        hazard_detected = 1'b0;
        branch_taken    = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_id(1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
            hazard_detected = 1'($urandom);
            branch_taken    = 1'($urandom);
            step();
            vectors++;
            if (all_out !== 18'd0) begin
                miscompares++;
                $display("FAIL reset_hold[%0d]: got %h expected 0", i, all_out);
            end
        end
        idle();
        rst_n = 1'b1;
        step();
        step();
        vectors++;
        if (all_out !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_release: got %h expected 0", all_out);
        end
    endtask

    task automatic test_forward();
        do_reset();
        set_id(1'b1, 4'd3, 1'b1, 1'b0);
        step();
        vectors++;
        if ({exe_dest, exe_wb_en} !== {4'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL fwd_exe: got dest=%0d wb=%b expected dest=3 wb=1", exe_dest, exe_wb_en);
        end
        idle();
        step();
        vectors++;
        if ({mem_dest, mem_wb_en, exe_wb_en} !== {4'd3, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL fwd_mem: got mem_dest=%0d mem_wb=%b exe_wb=%b expected 3 1 0",
                     mem_dest, mem_wb_en, exe_wb_en);
        end
        // Invalid ID: dest copied, enables dropped, no memory freeze later.
        set_id(1'b0, 4'd9, 1'b1, 1'b1);
        step();
        vectors++;
        if ({exe_dest, exe_wb_en} !== {4'd9, 1'b0}) begin
            miscompares++;
            $display("FAIL invalid_id: got dest=%0d wb=%b expected dest=9 wb=0", exe_dest, exe_wb_en);
        end
        idle();
        step();
        vectors++;
        if ({mem_dest, mem_wb_en, freeze_pipe} !== {4'd9, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL invalid_id_mem: got mem_dest=%0d wb=%b fp=%b expected 9 0 0",
                     mem_dest, mem_wb_en, freeze_pipe);
        end
    endtask

    task automatic test_hazard();
        do_reset();
        set_id(1'b1, 4'd5, 1'b1, 1'b0);
        step();
        set_id(1'b1, 4'd6, 1'b1, 1'b0);
        hazard_detected = 1'b1;
        #1;
        vectors++;
        if (ctrl !== 4'b1010) begin
            miscompares++;
            $display("FAIL hazard_ctrl: got %b expected 1010", ctrl);
        end
        step();
        hazard_detected = 1'b0;
        vectors++;
        if ({exe_wb_en, mem_dest, mem_wb_en, stall_cycles} !== {1'b0, 4'd5, 1'b1, 4'd1}) begin
            miscompares++;
            $display("FAIL hazard_after: got exe_wb=%b mem_dest=%0d mem_wb=%b stall=%0d expected 0 5 1 1",
                     exe_wb_en, mem_dest, mem_wb_en, stall_cycles);
        end
    endtask

    task automatic test_branch_priority();
        set_id(1'b1, 4'd6, 1'b1, 1'b0);
        hazard_detected = 1'b1;
        branch_taken    = 1'b1;
        #1;
        vectors++;
        if (ctrl !== 4'b0110) begin
            miscompares++;
            $display("FAIL branch_prio_ctrl: got %b expected 0110", ctrl);
        end
        step();
        idle();
        vectors++;
        if ({exe_wb_en, exe_dest, stall_cycles} !== {1'b0, 4'd0, 4'd1}) begin
            miscompares++;
            $display("FAIL branch_prio_after: got exe_wb=%b exe_dest=%0d stall=%0d expected 0 0 1",
                     exe_wb_en, exe_dest, stall_cycles);
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        set_id(1'b1, 4'd7, 1'b1, 1'b1);
        step();
        set_id(1'b1, 4'd9, 1'b0, 1'b0);
        step();
        set_id(1'b1, 4'd11, 1'b1, 1'b0);
        branch_taken = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            vectors++;
            if (ctrl !== 4'b1001) begin
                miscompares++;
                $display("FAIL mem_freeze_ctrl[%0d]: got %b expected 1001", c, ctrl);
            end
            step();
            vectors++;
            if ({exe_dest, mem_dest, mem_wb_en, stall_cycles} !== {4'd9, 4'd7, 1'b1, 4'(c + 1)}) begin
                miscompares++;
                $display("FAIL mem_hold[%0d]: got exe=%0d mem=%0d wb=%b stall=%0d expected 9 7 1 %0d",
                         c, exe_dest, mem_dest, mem_wb_en, stall_cycles, c + 1);
            end
        end
        #1;
        vectors++;
        if (ctrl !== 4'b0110) begin
            miscompares++;
            $display("FAIL mem_release_ctrl: got %b expected 0110", ctrl);
        end
        step();
        idle();
        #1;
        vectors++;
        if ({exe_wb_en, exe_dest, mem_dest, mem_wb_en, freeze_pipe, stall_cycles}
            !== {1'b0, 4'd0, 4'd9, 1'b0, 1'b0, 4'd2}) begin
            miscompares++;
            $display("FAIL mem_after_branch: got exe_wb=%b exe=%0d mem=%0d wb=%b fp=%b stall=%0d expected 0 0 9 0 0 2",
                     exe_wb_en, exe_dest, mem_dest, mem_wb_en, freeze_pipe, stall_cycles);
        end

        // Reset during WAIT must abort immediately.
        set_id(1'b1, 4'd7, 1'b1, 1'b1);
        step();
        idle();
        step();
        step();
        vectors++;
        if (freeze_pipe !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_entry: got freeze_pipe=%b expected 1", freeze_pipe);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (all_out !== 18'd0) begin
            miscompares++;
            $display("FAIL wait_abort: got %h expected 0", all_out);
        end
        step();
        rst_n = 1'b1;
        step();
        vectors++;
        if (all_out !== 18'd0) begin
            miscompares++;
            $display("FAIL wait_abort_release: got %h expected 0", all_out);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        hazard_detected = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 10 || i == 15 || i == 20) begin
                vectors++;
                if (stall_cycles !== 4'(i > 15 ? 15 : i)) begin
                    miscompares++;
                    $display("FAIL stall_sat[%0d]: got %0d expected %0d",
                             i, stall_cycles, (i > 15 ? 15 : i));
                end
            end
        end
        idle();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        idle();
        test_reset();
        test_forward();
        test_hazard();
        test_branch_priority();
        test_mem_wait();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Sequential producer side of the hazard interface for the 5-stage ARM pipeline.
- Tracks each in-flight instruction's destination register and write-back enable as it moves ID→EXE→MEM, and drives the Exe_Dest/Exe_WB_EN/Mem_Dest/Mem_WB_EN inputs of the hazard detection unit.
- Consumes Hazard_Detected, the EXE-stage branch-taken flag and a fixed-latency memory model.
- From these it generates IF freeze, ID flush, EXE bubble insertion and a whole-pipeline freeze, plus a stall-cycle performance counter.

Parameters:
- REG_W, 4, register index width.
- MEM_LAT, 2, total cycles a memory-accessing instruction occupies MEM (≥1).
- CNT_W, 16, width of stall_cycles counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- id_valid  input  1  ID holds a real instruction.
- id_dest  input  REG_W  ID instruction destination register.
- id_wb_en  input  1  ID instruction writes the register file.
- id_mem_acc  input  1  ID instruction is a load/store.
- hazard_detected  input  1  from hazard detection unit, same cycle.
- branch_taken  input  1  EXE-stage branch resolved taken.
- exe_dest  output  REG_W  destination of instruction in EXE.
- exe_wb_en  output  1  EXE instruction writes back.
- mem_dest  output  REG_W  destination of instruction in MEM.
- mem_wb_en  output  1  MEM instruction writes back.
- freeze_if  output  1  hold PC and IF/ID register.
- flush_id  output  1  clear IF/ID register.
- bubble_exe  output  1  load NOP into ID/EXE register.
- freeze_pipe  output  1  hold all pipeline registers (memory wait).
- stall_cycles  output  CNT_W  saturating count of freeze_if cycles.

Behaviour:
- Internal registers:
  - EXE slot {dest, wb_en, mem_acc} and MEM slot {dest, wb_en, mem_acc}.
  - state ∈ {RUN, WAIT} and wait_cnt.
  - stall_cycles.
- Reset (async, rst_n=0): all slot fields 0, state=RUN, wait_cnt=0, stall_cycles=0. All control outputs then evaluate to 0.
- Memory FSM; freeze_pipe is combinational from state, wait_cnt and the MEM slot:
  - RUN and MEM.mem_acc=1 and MEM_LAT>1: freeze_pipe=1; next state=WAIT, wait_cnt=MEM_LAT-2.
  - WAIT and wait_cnt≠0: freeze_pipe=1, wait_cnt decrements.
  - WAIT and wait_cnt=0: freeze_pipe=0, pipeline advances, next state=RUN.
  - MEM_LAT=1: freeze_pipe is never asserted.
- Control priority, all combinational, same cycle:
  - freeze_pipe=1: freeze_if=1, flush_id=0, bubble_exe=0. Both slots hold. branch_taken and hazard_detected are ignored; the branch stays in EXE and is re-evaluated later.
  - Else branch_taken=1: flush_id=1, bubble_exe=1, freeze_if=0. EXE slot←0, MEM slot←EXE slot.
  - Else hazard_detected=1: freeze_if=1, bubble_exe=1, flush_id=0. EXE slot←0, MEM slot←EXE slot.
  - Else: EXE slot←{id_dest, id_wb_en&id_valid, id_mem_acc&id_valid}, MEM slot←EXE slot. When id_valid=0, only dest is copied; the other fields are 0.
- Outputs exe_*/mem_* are the slot registers, so latency is one cycle per stage.
- stall_cycles increments on each clock where freeze_if=1 and saturates at 2^CNT_W-1.
- Reset asserted in WAIT aborts the wait immediately; after release, state=RUN and slots are empty.

Test Plan:
1. Hold rst_n=0, drive random inputs → all outputs 0. Release reset with idle inputs → outputs stay 0.
2. id_valid=1, id_dest=3, id_wb_en=1, then idle → exe_dest=3/exe_wb_en=1 after edge 1; mem_dest=3/mem_wb_en=1 after edge 2; exe_wb_en=0 after edge 2.
3. EXE holds dest 5 (wb_en=1); pulse hazard_detected=1 one cycle → freeze_if=1 and bubble_exe=1 that cycle. Next cycle: exe_wb_en=0, mem_dest=5, stall_cycles=1.
4. hazard_detected=1 and branch_taken=1 together → flush_id=1, bubble_exe=1, freeze_if=0, stall_cycles unchanged.
5. MEM_LAT=3: load (dest 7, mem_acc=1) reaches MEM → freeze_pipe=1 for exactly 2 cycles, slots held, branch_taken=1 during freeze ignored. Third cycle: freeze_pipe=0, branch acted on. Repeat with rst_n pulsed low during WAIT → immediate return to reset values.
6. CNT_W=4, hazard_detected held 20 cycles → stall_cycles climbs to 15 and stays 15.
